// File: rtl/match_sequence_tx_pkg.sv
// Shared constants, state encoding and helpers for the TX match-sequence generator.
package match_sequence_tx_pkg;

    localparam int NUM_WORDS      = 8;
    localparam int CHIPS_PER_WORD = 16;
    localparam int WORD_IDX_W     = 3;
    localparam int CHIP_IDX_W     = 7;
    localparam int SAMPLE_W       = 16;
    localparam int CDATA_W        = 32;

    // Bit positions of the fields inside a parameter-write cdata word
    localparam int AMP_MSB   = 31;
    localparam int AMP_LSB   = 16;
    localparam int WORDS_MSB = 6;
    localparam int WORDS_LSB = 4;
    localparam int RESID_MSB = 3;
    localparam int RESID_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    function automatic logic [CHIP_IDX_W-1:0] seq_length(
        input logic [WORDS_MSB-WORDS_LSB:0] full_words,
        input logic [RESID_MSB-RESID_LSB:0] residual
    );
        return {full_words, 4'b0000} + {3'b000, residual};
    endfunction

    // A set chip bit means +1; the negative chip is the 16-bit two's complement
    function automatic logic [SAMPLE_W-1:0] scale_chip(
        input logic                sign_bit,
        input logic [SAMPLE_W-1:0] amplitude
    );
        return sign_bit ? amplitude : (~amplitude + 16'd1);
    endfunction

endpackage

// File: rtl/match_sequence_tx_seq_coeff_bank.sv
// Coefficient register file: one write port, one asynchronous read port by word index.
module seq_coeff_bank
    import match_sequence_tx_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_we,
    input  logic [WORD_IDX_W-1:0] i_waddr,
    input  logic [CDATA_W-1:0]    i_wdata,
    input  logic [WORD_IDX_W-1:0] i_raddr,
    output logic [CDATA_W-1:0]    o_rdata
);

    logic [CDATA_W-1:0] r_mem [NUM_WORDS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                r_mem[k] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/match_sequence_tx.sv
// Emits a programmed +/-1 chip sequence as scaled I/Q samples on the TX sample strobe.
module match_sequence_tx
    import match_sequence_tx_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CDATA_W-1:0]    cdata,
    input  logic [WORD_IDX_W-1:0] cstate,
    input  logic                  cwrite,
    input  logic                  cparam,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  txstrobe,
    output logic [SAMPLE_W-1:0]   i_out,
    output logic [SAMPLE_W-1:0]   q_out,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           debugbus
);

    seq_state_t                    r_state;
    logic [CHIP_IDX_W-1:0]         r_chip_idx;
    logic [SAMPLE_W-1:0]           r_amplitude;
    logic [WORDS_MSB-WORDS_LSB:0]  r_full_words;
    logic [RESID_MSB-RESID_LSB:0]  r_residual;
    logic [SAMPLE_W-1:0]           r_i_out;
    logic [SAMPLE_W-1:0]           r_q_out;
    logic                          r_out_valid;
    logic                          r_busy;
    logic                          r_done;
    logic                          r_cerr;

    logic                          w_bank_we;
    logic                          w_param_we;
    logic [CHIP_IDX_W-1:0]         w_seq_len;
    logic [CHIP_IDX_W-1:0]         w_last_idx;
    logic [WORD_IDX_W-1:0]         w_word_sel;
    logic [3:0]                    w_bit_sel;
    logic [CDATA_W-1:0]            w_coeff_word;
    logic [CHIPS_PER_WORD-1:0]     w_real_bits;
    logic [CHIPS_PER_WORD-1:0]     w_imag_bits;
    logic                          w_real_sign;
    logic                          w_imag_sign;
    logic [1:0]                    w_state_bits;

    // Control-bus writes are only honoured while idle so a running sequence never changes
    assign w_param_we = cwrite &  cparam & ~r_busy;
    assign w_bank_we  = cwrite & ~cparam & ~r_busy;

    assign w_seq_len  = seq_length(r_full_words, r_residual);
    assign w_last_idx = w_seq_len - 7'd1;

    assign w_word_sel  = r_chip_idx[CHIP_IDX_W-1:4];
    assign w_bit_sel   = r_chip_idx[3:0];
    assign w_real_bits = w_coeff_word[CDATA_W-1:CHIPS_PER_WORD];
    assign w_imag_bits = w_coeff_word[CHIPS_PER_WORD-1:0];
    assign w_real_sign = w_real_bits[w_bit_sel];
    assign w_imag_sign = w_imag_bits[w_bit_sel];

    seq_coeff_bank u_bank (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_bank_we),
        .i_waddr (cstate),
        .i_wdata (cdata),
        .i_raddr (w_word_sel),
        .o_rdata (w_coeff_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_amplitude  <= '0;
            r_full_words <= '0;
            r_residual   <= '0;
        end else if (w_param_we) begin
            r_amplitude  <= cdata[AMP_MSB:AMP_LSB];
            r_full_words <= cdata[WORDS_MSB:WORDS_LSB];
            r_residual   <= cdata[RESID_MSB:RESID_LSB];
        end
    end

    // Sticky debug flag: a control write arrived while a sequence was in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cerr <= 1'b0;
        end else if (cwrite && r_busy) begin
            r_cerr <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_chip_idx  <= '0;
            r_i_out     <= '0;
            r_q_out     <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && (w_seq_len != '0)) begin
                        r_state    <= ST_RUN;
                        r_busy     <= 1'b1;
                        r_chip_idx <= '0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_i_out <= '0;
                        r_q_out <= '0;
                    end else if (txstrobe) begin
                        r_i_out     <= scale_chip(w_real_sign, r_amplitude);
                        r_q_out     <= scale_chip(w_imag_sign, r_amplitude);
                        r_out_valid <= 1'b1;
                        if (r_chip_idx == w_last_idx) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_chip_idx <= r_chip_idx + 7'd1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_i_out <= '0;
                    r_q_out <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign w_state_bits = r_state;

    assign i_out     = r_i_out;
    assign q_out     = r_q_out;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign debugbus  = {w_state_bits, r_chip_idx, r_out_valid, r_busy, r_done, r_cerr, 3'b000};

endmodule

// File: tb/tb_match_sequence_tx.sv
// Directed scoreboard bench for match_sequence_tx: stimulus queues expected chips, a monitor checks them.
module tb_match_sequence_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cdata;
    logic [2:0]  cstate;
    logic        cwrite;
    logic        cparam;
    logic        start;
    logic        abort;
    logic        txstrobe;
    logic [15:0] i_out;
    logic [15:0] q_out;
    logic        out_valid;
    logic        busy;
    logic        done;
    logic [15:0] debugbus;

    typedef struct {
        logic [15:0] i;
        logic [15:0] q;
    } sample_t;

    sample_t     expQ[$];
    int          nCompared   = 0;
    int          nMismatched = 0;
    int          doneCount   = 0;
    int          doneBefore;
    logic [31:0] tbBank [8];
    logic [15:0] tbAmp;

    match_sequence_tx dut (
        .clk       (clk),
        .reset     (reset),
        .cdata     (cdata),
        .cstate    (cstate),
        .cwrite    (cwrite),
        .cparam    (cparam),
        .start     (start),
        .abort     (abort),
        .txstrobe  (txstrobe),
        .i_out     (i_out),
        .q_out     (q_out),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done),
        .debugbus  (debugbus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every out_valid must match the oldest queued expectation
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL unexpected_valid: got i=%h q=%h with nothing expected at %0t", i_out, q_out, $time);
            end else begin
                sample_t e;
                e = expQ.pop_front();
                checkOutput("i_out", {16'h0, i_out}, {16'h0, e.i});
                checkOutput("q_out", {16'h0, q_out}, {16'h0, e.q});
            end
        end
        if (done === 1'b1) doneCount++;
    end

    task automatic applyStimulus(input logic s, input logic a, input logic t);
        start    = s;
        abort    = a;
        txstrobe = t;
        @(posedge clk); #1;
        start    = 1'b0;
        abort    = 1'b0;
        txstrobe = 1'b0;
    endtask

    task automatic busWrite(input logic isParam, input logic [2:0] idx, input logic [31:0] data);
        cwrite = 1'b1;
        cparam = isParam;
        cstate = idx;
        cdata  = data;
        @(posedge clk); #1;
        cwrite = 1'b0;
        cparam = 1'b0;
    endtask

    task automatic progCoeff(input logic [2:0] idx, input logic [31:0] data);
        busWrite(1'b0, idx, data);
        tbBank[idx] = data;
    endtask

    task automatic progParam(input logic [15:0] amp, input logic [2:0] w, input logic [3:0] res);
        busWrite(1'b1, 3'd0, {amp, 9'h0, w, res});
        tbAmp = amp;
    endtask

    task automatic strobe();
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic pushSample(input logic [15:0] iv, input logic [15:0] qv);
        sample_t s;
        s.i = iv;
        s.q = qv;
        expQ.push_back(s);
    endtask

    function automatic logic [15:0] chipValue(input logic sgn);
        return sgn ? tbAmp : 16'(16'd0 - tbAmp);
    endfunction

    task automatic pushChip(input int idx);
        logic [31:0] w;
        w = tbBank[idx / 16];
        pushSample(chipValue(w[16 + (idx % 16)]), chipValue(w[idx % 16]));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; cdata = '0; cstate = '0; cwrite = 1'b0; cparam = 1'b0;
        start = 1'b0; abort = 1'b0; txstrobe = 1'b0;
        for (int k = 0; k < 8; k++) tbBank[k] = '0;
        tbAmp = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checkOutput("rst_i_out", {16'h0, i_out}, 32'h0);
        checkOutput("rst_q_out", {16'h0, q_out}, 32'h0);
        checkOutput("rst_flags", {29'h0, out_valid, busy, done}, 32'h0);
        checkOutput("rst_debugbus", {16'h0, debugbus}, 32'h0);

        $display("[TB] test 1: single full word");
        progCoeff(3'd0, 32'hFFFF_0000);
        progParam(16'd100, 3'd1, 4'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t1_busy", {31'h0, busy}, 32'h1);
        for (int k = 0; k < 16; k++) begin
            pushSample(16'd100, 16'hFF9C);
            strobe();
        end
        checkOutput("t1_done", {31'h0, done}, 32'h1);
        checkOutput("t1_busy_low", {31'h0, busy}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t1_done_pulse", {31'h0, done}, 32'h0);
        checkOutput("t1_done_count", doneCount, 32'd1);
        checkOutput("t1_drained", expQ.size(), 32'd0);

        $display("[TB] test 2: residual-only sequence");
        progParam(16'h0400, 3'd0, 4'd5);
        progCoeff(3'd0, 32'h0005_000A);
        applyStimulus(1'b1, 1'b0, 1'b0);
        pushSample(16'h0400, 16'hFC00);
        pushSample(16'hFC00, 16'h0400);
        pushSample(16'h0400, 16'hFC00);
        pushSample(16'hFC00, 16'h0400);
        pushSample(16'hFC00, 16'hFC00);
        for (int k = 0; k < 5; k++) strobe();
        checkOutput("t2_done", {31'h0, done}, 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t2_no_sixth", {31'h0, out_valid}, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t2_done_count", doneCount, 32'd2);
        checkOutput("t2_drained", expQ.size(), 32'd0);

        $display("[TB] test 3: zero-length sequence");
        progParam(16'd100, 3'd0, 4'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t3_busy", {31'h0, busy}, 32'h0);
        for (int k = 0; k < 50; k++) strobe();
        checkOutput("t3_busy_end", {31'h0, busy}, 32'h0);
        checkOutput("t3_done_count", doneCount, 32'd2);

        $display("[TB] test 4: abort and replay, L=40");
        progCoeff(3'd0, 32'h1234_ABCD);
        progCoeff(3'd1, 32'hF0F0_0F0F);
        progCoeff(3'd2, 32'h8001_7FFE);
        progParam(16'd300, 3'd2, 4'd8);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t4_dbg_run", {16'h0, debugbus & 16'hC07F}, 32'h4020);
        for (int k = 0; k <= 10; k++) begin
            pushChip(k);
            strobe();
        end
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("t4_abort_busy", {31'h0, busy}, 32'h0);
        checkOutput("t4_abort_iq", {i_out, q_out}, 32'h0);
        checkOutput("t4_abort_valid", {31'h0, out_valid}, 32'h0);
        for (int k = 0; k < 3; k++) strobe();
        checkOutput("t4_abort_nodone", doneCount, 32'd2);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            pushChip(k);
            strobe();
        end
        checkOutput("t4_done", {31'h0, done}, 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t4_done_count", doneCount, 32'd3);
        checkOutput("t4_drained", expQ.size(), 32'd0);

        $display("[TB] test 5: writes and start while busy");
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            pushChip(k);
            strobe();
        end
        busWrite(1'b0, 3'd0, 32'h0000_0000);
        busWrite(1'b1, 3'd0, {16'd5, 16'h0011});
        checkOutput("t5_cerr", {31'h0, debugbus[3]}, 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int k = 3; k < 40; k++) begin
            pushChip(k);
            strobe();
        end
        checkOutput("t5_done", {31'h0, done}, 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t5_idle_dbg", {16'h0, debugbus & 16'hC07F}, 32'h0008);
        checkOutput("t5_done_count", doneCount, 32'd4);
        checkOutput("t5_drained", expQ.size(), 32'd0);

        $display("[TB] test 6: asynchronous reset mid-run");
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            pushChip(k);
            strobe();
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t6_pre_iq_live", {31'h0, (i_out != 16'h0)}, 32'h1);
        #3 reset = 1'b1;
        #1;
        checkOutput("t6_rst_iq", {i_out, q_out}, 32'h0);
        checkOutput("t6_rst_flags", {29'h0, out_valid, busy, done}, 32'h0);
        checkOutput("t6_rst_debugbus", {16'h0, debugbus}, 32'h0);
        @(posedge clk); #1 reset = 1'b0;
        for (int k = 0; k < 8; k++) tbBank[k] = '0;
        tbAmp = '0;
        doneBefore = doneCount;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t6_start_ignored", {31'h0, busy}, 32'h0);
        for (int k = 0; k < 5; k++) strobe();
        checkOutput("t6_no_done", doneCount, doneBefore);
        checkOutput("t6_drained", expQ.size(), 32'd0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
